// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its command front-end:
// FSM state encoding, default widths and ALU select codes.
package alu_pkg;

  localparam int W_DEF     = 4;
  localparam int SEL_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;
  localparam logic [2:0] SEL_XOR  = 3'b100;
  localparam logic [2:0] SEL_NOTA = 3'b101;
  localparam logic [2:0] SEL_SHL  = 3'b110;
  localparam logic [2:0] SEL_SHR  = 3'b111;

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Command and result handshake bundle for alu_cmd_ctrl.
// master = command source / result sink, slave = the controller.
interface alu_cmd_ctrl_if
  import alu_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [SEL_W-1:0] in_sel;
  logic             in_use_acc;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_y;

  modport master (
    output in_valid, in_a, in_b, in_sel, in_use_acc, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_use_acc, out_ready,
    output in_ready, out_valid, out_y
  );

endinterface

// File: rtl/alu_cmd_ctrl_fsm.sv
// IDLE/ISSUE/HOLD sequencer for alu_cmd_ctrl: state register, handshake
// decode and datapath load strobes.
module alu_cmd_ctrl_fsm
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  input  logic out_ready_i,
  output logic in_ready_o,
  output logic accept_o,
  output logic capture_o,
  output logic out_valid_o,
  output logic busy_o
);

  state_e state_q;
  logic   out_valid_q;
  logic   busy_q;

  // Ready in HOLD follows out_ready so a drained result frees the slot at once.
  assign in_ready_o  = (state_q == IDLE) | ((state_q == HOLD) & out_ready_i);
  assign accept_o    = in_valid_i & in_ready_o;
  assign capture_o   = (state_q == ISSUE);
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          state_q     <= HOLD;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b1;
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (in_valid_i) begin
              state_q <= ISSUE;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command front-end for the combinational ALU: registers operands, captures
// the result one cycle later. Optional accumulator feedback: ALU_CMD_ACC_EN.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_ctrl_if.slave    cmd,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [W-1:0]     alu_y,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  logic accept;
  logic capture;

  logic [W-1:0]     alu_a_q,    alu_a_d;
  logic [W-1:0]     alu_b_q,    alu_b_d;
  logic [SEL_W-1:0] alu_sel_q,  alu_sel_d;
  logic [W-1:0]     out_y_q,    out_y_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  alu_cmd_ctrl_fsm u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (cmd.in_valid),
    .out_ready_i (cmd.out_ready),
    .in_ready_o  (cmd.in_ready),
    .accept_o    (accept),
    .capture_o   (capture),
    .out_valid_o (cmd.out_valid),
    .busy_o      (busy)
  );

`ifdef ALU_CMD_ACC_EN
  logic [W-1:0] acc_q, acc_d;

  // accept and capture never coincide, so acc_q at accept is the latest result.
  always_comb begin
    acc_d = acc_q;
    if (capture) begin
      acc_d = alu_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  logic unused_use_acc;
  assign unused_use_acc = cmd.in_use_acc;
`endif

  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    out_y_d    = out_y_q;
    op_count_d = op_count_q;
    if (accept) begin
      alu_a_d   = cmd.in_a;
`ifdef ALU_CMD_ACC_EN
      if (cmd.in_use_acc) begin
        alu_a_d = acc_q;
      end
`endif
      alu_b_d   = cmd.in_b;
      alu_sel_d = cmd.in_sel;
    end
    if (capture) begin
      out_y_d    = alu_y;
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      out_y_q    <= '0;
      op_count_q <= '0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      out_y_q    <= out_y_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign cmd.out_y = out_y_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Sequential command front-end that sits directly upstream of the combinational 4-bit ALU. Accepts operand/select commands on a valid/ready handshake, registers them onto the ALU inputs, captures the ALU result one cycle later and presents it on a valid/ready output with back-pressure. An optional accumulator path feeds the previous result back as operand A.

## Interface
- W, 4: operand and result width; must match the ALU.
- SEL_W, 3: ALU select width.
- CNT_W, 8: width of the completed-operation counter.
- clk  in  1  the single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  command valid.
- in_ready  out  1  command can be accepted this cycle.
- in_a, in_b  in  W  operands.
- in_sel  in  SEL_W  ALU operation select, passed through unmodified.
- in_use_acc  in  1  use the accumulator in place of in_a (only with ALU_CMD_ACC_EN).
- alu_a, alu_b  out  W  registered operands to the ALU.
- alu_sel  out  SEL_W  registered select to the ALU.
- alu_y  in  W  combinational ALU result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  W  registered result.
- busy  out  1  high in any state except IDLE.
- op_count  out  CNT_W  number of results captured, mod 2^CNT_W.

## Operation
- FSM states: IDLE, ISSUE, HOLD.
- IDLE: in_ready=1. If in_valid, latch alu_a/alu_b/alu_sel and go to ISSUE.
- ISSUE: in_ready=0. The ALU settles during this cycle. At the end of the cycle, capture alu_y into out_y, increment op_count, and go to HOLD.
- HOLD: out_valid=1. out_y, alu_a, alu_b and alu_sel stay stable until the result is accepted.
  - out_ready=0: stay in HOLD.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=1 and in_valid=1: accept the new command in the same cycle and go to ISSUE (back-to-back).
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This is combinational from out_ready; there is no other in-to-out combinational path.
- Operands are not transformed. No width growth; truncation and overflow are the ALU's concern.
- op_count wraps from 2^CNT_W-1 to 0 without saturating.
- Commands presented while in_ready=0 are ignored. The source must hold in_valid and its data stable.

## Timing
- Reset, asynchronous on rst_n low: state=IDLE; alu_a, alu_b, alu_sel, out_y, op_count and acc = 0; out_valid=0; busy=0.
- Reset in ISSUE or HOLD discards the pending result. No out_valid pulse follows.
- Latency: command accepted at edge N; alu_* valid after N; out_valid=1 after edge N+1.
- Throughput: one result per 2 cycles with out_ready held high.
- out_valid falls on the edge after the out_ready handshake, unless a back-to-back command moves the FSM to ISSUE. In that case out_valid=0 for exactly one cycle.

## Configuration
- ALU_CMD_ACC_EN defined:
  - A W-bit acc register loads out_y's new value on every capture.
  - On accept with in_use_acc=1, alu_a takes acc instead of in_a.
  - In a back-to-back accept, acc already holds the result being drained.
- ALU_CMD_ACC_EN undefined: in_use_acc is ignored, no acc register exists, and alu_a always takes in_a.

## Structure
- The shared package alu_pkg holds the FSM state enum (IDLE/ISSUE/HOLD), default widths W=4 and SEL_W=3, and the select-code constants shared with the ALU.
- Sub-module alu_cmd_ctrl_fsm holds the state register and next-state/handshake decode. Datapath registers stay in the top.

## Test plan
- Reset and single command. Reset held low mid-stream, then released. in_a=4, in_b=2, in_sel=3'b000 at edge N. Required:
  - all outputs 0 during reset;
  - alu_a=4, alu_b=2, alu_sel=0 after N;
  - a bench ALU stub drives alu_y=6;
  - out_valid=1 and out_y=6 after N+1;
  - op_count=1.
- Back-pressure. out_ready=0 for 5 cycles in HOLD, with in_valid=1 and new operands presented. Required: in_ready=0; out_y, alu_a, alu_b and alu_sel unchanged; op_count unchanged. On out_ready=1, the new command is accepted that same cycle.
- Back-to-back. Sel sweep 000→111 with out_ready=1 and in_valid=1 throughout. Required: 8 results at 2-cycle spacing, alu_sel order matches the input order, op_count=8.
- Accumulator (ALU_CMD_ACC_EN). The first result is 4'b1000. The next command has in_use_acc=1 and in_a=1. Required: alu_a=4'b1000. Without the macro, the same stimulus gives alu_a=1.
- Reset mid-operation. Assert rst_n=0 asynchronously during ISSUE. Required: out_valid never rises; state is IDLE and op_count=0 after release.
- Counter wrap. With CNT_W=2, run 5 operations. Required: op_count sequence 1,2,3,0,1.
